// File: rtl/bsg_tag_arb_pkg.sv
// Shared definitions for the bsg_tag packet arbiter.
//   - arb_state_e : arbiter FSM states
//   - safe_clog2 / max_int : sizing helpers matching BSG_SAFE_CLOG2 / BSG_MAX
//   - node_w / len_w / hdr_w / frame_w : field and frame widths from parameters
//   - tag_hdr_s : header layout {nodeID, data_not_reset, len} for the default
//     configuration (16 clients, 16-bit payload); len sits in the LSBs.
package bsg_tag_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FLUSH = 2'd3
  } arb_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int node_w(input int num_clients);
    return safe_clog2(num_clients);
  endfunction

  function automatic int len_w(input int payload_w);
    return safe_clog2(payload_w + 1);
  endfunction

  function automatic int hdr_w(input int num_clients, input int payload_w);
    return node_w(num_clients) + 1 + len_w(payload_w);
  endfunction

  // Start bit + header + payload + trailing zero.
  function automatic int frame_w(input int num_clients, input int payload_w);
    return payload_w + hdr_w(num_clients, payload_w) + 2;
  endfunction

  typedef struct packed {
    logic [3:0] node_id;
    logic       data_not_reset;
    logic [4:0] len;
  } tag_hdr_s;

endpackage

// File: rtl/bsg_tag_frame_shifter.sv
// Loadable right-shift register plus down-counter for the serial tag frame.
// Ports:
//   clk_i, reset_n_i    : clock, synchronous active-low reset
//   load_i, data_i      : parallel load of a full frame (wins over shift)
//   shift_i             : shift right by one, zero-filling from the top
//   cnt_load_i, cnt_val_i : load the down-counter
//   cnt_dec_i           : decrement the down-counter
//   bit_o               : current LSB of the shift register
//   cnt_zero_o          : counter equals zero
module bsg_tag_frame_shifter
  import bsg_tag_arb_pkg::*;
#(
  parameter int width_p     = 28,
  parameter int cnt_width_p = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   shift_i,
  input  logic                   cnt_load_i,
  input  logic [cnt_width_p-1:0] cnt_val_i,
  input  logic                   cnt_dec_i,
  output logic                   bit_o,
  output logic                   cnt_zero_o
);

  logic [width_p-1:0]     sr_q;
  logic [cnt_width_p-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i)
        sr_q <= data_i;
      else if (shift_i)
        sr_q <= {1'b0, sr_q[width_p-1:1]};

      if (cnt_load_i)
        cnt_q <= cnt_val_i;
      else if (cnt_dec_i)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_o      = sr_q[0];
  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_tag_packet_arbiter.sv
// Round-robin arbiter sharing one bit-serial bsg_tag line among num_req_p
// packet sources. Each grant is framed as {0, payload, header, 1} and shifted
// out LSB first, followed by gap_cycles_p idle zeros. A flush request emits
// flush_cycles_p zeros (master reset) and takes priority over packets.
// Ports:
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   en_i             : permits new grants (frames in flight always complete)
//   flush_i          : flush request, sampled in IDLE
//   req_v_i          : per-requester valid
//   req_hdr_i        : per-requester header {nodeID, data_not_reset, len}
//   req_payload_i    : per-requester payload
//   req_en_i         : per-requester master enables (ignored if num_masters_p==0)
//   req_yumi_o       : one-hot consume strobe, combinational, IDLE only
//   tag_data_o       : serial bsg_tag data
//   en_r_o           : registered master enables of the last grant
//   grant_id_o       : index of the current or last grant
//   busy_o           : FSM is not IDLE
module bsg_tag_packet_arbiter
  import bsg_tag_arb_pkg::*;
#(
  parameter int num_req_p           = 2,
  parameter int num_clients_p       = 16,
  parameter int max_payload_width_p = 16,
  parameter int num_masters_p       = 1,
  parameter int gap_cycles_p        = 2,
  parameter int flush_cycles_p      = 64,
  localparam int H_W  = hdr_w(num_clients_p, max_payload_width_p),
  localparam int D_W  = max_payload_width_p,
  localparam int ME_W = max_int(1, num_masters_p),
  localparam int RW   = safe_clog2(num_req_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic [num_req_p-1:0]      req_v_i,
  input  logic [num_req_p*H_W-1:0]  req_hdr_i,
  input  logic [num_req_p*D_W-1:0]  req_payload_i,
  input  logic [num_req_p*ME_W-1:0] req_en_i,
  output logic [num_req_p-1:0]      req_yumi_o,
  output logic                      tag_data_o,
  output logic [ME_W-1:0]           en_r_o,
  output logic [RW-1:0]             grant_id_o,
  output logic                      busy_o
);

  localparam int F_W  = frame_w(num_clients_p, max_payload_width_p);
  localparam int CMAX = max_int(F_W, max_int(gap_cycles_p, flush_cycles_p)) - 1;
  localparam int CW   = safe_clog2(CMAX + 1);

  localparam logic [CW-1:0] FrameCnt = CW'(F_W - 1);
  localparam logic [CW-1:0] GapCnt   = CW'(gap_cycles_p - 1);
  localparam logic [CW-1:0] FlushCnt = CW'(flush_cycles_p - 1);

  arb_state_e      state_q, state_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   grant_q, grant_d;
  logic [ME_W-1:0] en_q, en_d;

  logic            found;
  logic [RW-1:0]   sel;

  logic            sh_load, sh_shift, sh_cnt_load, sh_cnt_dec;
  logic [F_W-1:0]  sh_data;
  logic [CW-1:0]   sh_cnt_val;
  logic            sh_bit, sh_cnt_zero;

  // Round-robin pick: first valid requester at or after the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && req_v_i[RW'((int'(ptr_q) + i) % num_req_p)]) begin
        found = 1'b1;
        sel   = RW'((int'(ptr_q) + i) % num_req_p);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    en_d        = en_q;
    req_yumi_o  = '0;
    sh_load     = 1'b0;
    sh_data     = '0;
    sh_shift    = 1'b0;
    sh_cnt_load = 1'b0;
    sh_cnt_val  = '0;
    sh_cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d     = FLUSH;
          sh_cnt_load = 1'b1;
          sh_cnt_val  = FlushCnt;
        end else if (en_i && found) begin
          req_yumi_o[sel] = 1'b1;
          sh_load     = 1'b1;
          sh_data     = {1'b0,
                         req_payload_i[int'(sel)*D_W +: D_W],
                         req_hdr_i[int'(sel)*H_W +: H_W],
                         1'b1};
          sh_cnt_load = 1'b1;
          sh_cnt_val  = FrameCnt;
          grant_d     = sel;
          ptr_d       = (int'(sel) + 1 >= num_req_p) ? '0 : RW'(int'(sel) + 1);
          if (num_masters_p > 0)
            en_d = req_en_i[int'(sel)*ME_W +: ME_W];
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        sh_shift = 1'b1;
        if (sh_cnt_zero) begin
          state_d     = GAP;
          sh_cnt_load = 1'b1;
          sh_cnt_val  = GapCnt;
        end else begin
          sh_cnt_dec = 1'b1;
        end
      end
      GAP, FLUSH: begin
        if (sh_cnt_zero)
          state_d = IDLE;
        else
          sh_cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
    end
  end

  bsg_tag_frame_shifter #(
    .width_p    (F_W),
    .cnt_width_p(CW)
  ) u_shifter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (sh_load),
    .data_i    (sh_data),
    .shift_i   (sh_shift),
    .cnt_load_i(sh_cnt_load),
    .cnt_val_i (sh_cnt_val),
    .cnt_dec_i (sh_cnt_dec),
    .bit_o     (sh_bit),
    .cnt_zero_o(sh_cnt_zero)
  );

  // Only SHIFT exposes the shift register; every other state drives idle zeros.
  assign tag_data_o = (state_q == SHIFT) && sh_bit;
  assign en_r_o     = en_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule
